// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port sequencer and its helpers.
package regfile_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned idx;

    // Walk from the farthest position back to rr_ptr so the nearest valid requester is the last writer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            idx = (int'(rr_ptr) + k - 1) % NUM_REQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file's single write port: clears every register after reset,
// then shares the port round-robin among NUM_REQ writeback requesters.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           writeRegister,
    output logic [DATA_W-1:0]           writeData,
    output logic                        RegWrite,
    output logic                        init_done,
    output logic                        contention
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [ADDR_W-1:0]    init_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic [ADDR_W-1:0]    sel_reg;
    logic [DATA_W-1:0]    sel_data;
    logic [IDX_W-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are suppressed combinationally while reset is asserted, not just after it is sampled.
    assign req_ready = (reset_n && state == ST_RUN) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel_reg   = req_reg[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];
    assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_INIT;
            init_idx      <= '0;
            rr_ptr        <= '0;
            RegWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            init_done     <= 1'b0;
            contention    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    RegWrite      <= 1'b1;
                    writeRegister <= init_idx;
                    writeData     <= '0;
                    init_idx      <= init_idx + 1'b1;
                    contention    <= 1'b0;
                    if (init_idx == ADDR_W'(NUM_REGS - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    contention <= ($countones(req_valid) >= 2);
                    if (accept) begin
                        writeRegister <= sel_reg;
                        writeData     <= sel_data;
                        // Writes to $zero complete the handshake but never reach the register file.
                        RegWrite      <= (sel_reg != ADDR_W'(ZERO_REG));
                        rr_ptr        <= next_ptr;
                    end else begin
                        RegWrite <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, corner sequences and a randomized run.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    logic                        clock = 1'b0;
    logic                        reset_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_reg;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [ADDR_W-1:0]           writeRegister;
    logic [DATA_W-1:0]           writeData;
    logic                        RegWrite;
    logic                        init_done;
    logic                        contention;

    regfile_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .RegWrite      (RegWrite),
        .init_done     (init_done),
        .contention    (contention)
    );

    always #5 clock = ~clock;

    // Register file fed by the DUT outputs, as the real one would be.
    logic [DATA_W-1:0] dut_rf [NUM_REGS];
    always @(posedge clock) begin
        if (RegWrite) dut_rf[writeRegister] <= writeData;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                m_run;
    int                m_idx;
    int                m_ptr;
    logic              m_rw;
    logic [ADDR_W-1:0] m_wr;
    logic [DATA_W-1:0] m_wd;
    logic              m_done;
    logic              m_cont;
    logic [DATA_W-1:0] ref_rf [NUM_REGS];
    int                last_grant;
    logic [NUM_REQ-1:0] ready_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check the combinational grant, advance the model, check registered outputs.
    task automatic step();
        int g;
        int best;
        int r;
        logic [NUM_REQ-1:0] exp_ready;
        #1;
        g    = -1;
        best = NUM_REQ;
        if (reset_n && m_run) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && ((i - m_ptr + NUM_REQ) % NUM_REQ) < best) begin
                    best = (i - m_ptr + NUM_REQ) % NUM_REQ;
                    g    = i;
                end
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        ready_seen = req_ready;
        chk("req_ready", req_ready, exp_ready);
        last_grant = g;
        @(posedge clock);
        if (!reset_n) begin
            m_run = 0; m_idx = 0; m_ptr = 0;
            m_rw = 0; m_wr = '0; m_wd = '0; m_done = 0; m_cont = 0;
        end else if (!m_run) begin
            m_rw = 1; m_wr = ADDR_W'(m_idx); m_wd = '0; m_cont = 0;
            ref_rf[m_idx] = '0;
            if (m_idx == NUM_REGS - 1) begin
                m_run = 1; m_done = 1;
            end
            m_idx++;
        end else begin
            m_cont = ($countones(req_valid) >= 2);
            if (g >= 0) begin
                r    = int'(req_reg[g*ADDR_W +: ADDR_W]);
                m_wr = ADDR_W'(r);
                m_wd = req_data[g*DATA_W +: DATA_W];
                m_rw = (r != 0);
                if (r != 0) ref_rf[r] = m_wd;
                m_ptr = (g + 1) % NUM_REQ;
            end else begin
                m_rw = 0;
            end
        end
        #1;
        chk("RegWrite", RegWrite, m_rw);
        chk("writeRegister", writeRegister, m_wr);
        chk("writeData", writeData, m_wd);
        chk("init_done", init_done, m_done);
        chk("contention", contention, m_cont);
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        req_valid[i]              = v;
        req_reg[i*ADDR_W +: ADDR_W] = r;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    typedef struct {
        logic [1:0]        valid;
        logic [ADDR_W-1:0] r0;
        logic [DATA_W-1:0] d0;
        logic [ADDR_W-1:0] r1;
        logic [DATA_W-1:0] d1;
        logic [1:0]        ready;
        logic              rw;
        logic [ADDR_W-1:0] wr;
        logic [DATA_W-1:0] wd;
        logic              cont;
    } vec_t;

    vec_t vecs [10];

    logic              pend_v [NUM_REQ];
    logic [ADDR_W-1:0] pend_r [NUM_REQ];
    logic [DATA_W-1:0] pend_d [NUM_REQ];

    initial begin
        // Applied from pointer 0 on the first RUN cycle.
        vecs[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{2'b10, 5'd0, 32'h0,        5'd0, 32'hFFFFFFFF, 2'b10, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{2'b11, 5'd3, 32'h11,       5'd4, 32'h22,       2'b01, 1'b1, 5'd3, 32'h11,       1'b1};
        vecs[4] = '{2'b11, 5'd3, 32'h11,       5'd4, 32'h22,       2'b10, 1'b1, 5'd4, 32'h22,       1'b1};
        vecs[5] = '{2'b11, 5'd3, 32'h11,       5'd4, 32'h22,       2'b01, 1'b1, 5'd3, 32'h11,       1'b1};
        vecs[6] = '{2'b11, 5'd3, 32'h11,       5'd4, 32'h22,       2'b10, 1'b1, 5'd4, 32'h22,       1'b1};
        vecs[7] = '{2'b00, 5'd3, 32'h11,       5'd4, 32'h22,       2'b00, 1'b0, 5'd4, 32'h22,       1'b0};
        vecs[8] = '{2'b10, 5'd3, 32'h11,       5'd7, 32'h77,       2'b10, 1'b1, 5'd7, 32'h77,       1'b0};
        vecs[9] = '{2'b10, 5'd3, 32'h11,       5'd7, 32'h77,       2'b10, 1'b1, 5'd7, 32'h77,       1'b0};

        m_run = 0; m_idx = 0; m_ptr = 0;
        m_rw = 0; m_wr = '0; m_wd = '0; m_done = 0; m_cont = 0;
        for (int i = 0; i < NUM_REGS; i++) ref_rf[i] = '0;
        req_valid = '0; req_reg = '0; req_data = '0;

        // Reset for two cycles, then the full clear sweep with no requests.
        reset_n = 1'b0;
        run_steps(2);
        reset_n = 1'b1;
        run_steps(NUM_REGS);
        chk("sweep_done", init_done, 1'b1);

        for (int v = 0; v < 10; v++) begin
            req_valid = vecs[v].valid;
            req_reg   = {vecs[v].r1, vecs[v].r0};
            req_data  = {vecs[v].d1, vecs[v].d0};
            step();
            chk("tbl_ready", ready_seen, vecs[v].ready);
            chk("tbl_rw", RegWrite, vecs[v].rw);
            chk("tbl_wr", writeRegister, vecs[v].wr);
            chk("tbl_wd", writeData, vecs[v].wd);
            chk("tbl_cont", contention, vecs[v].cont);
        end
        req_valid = '0;
        run_steps(2);
        chk("zero_reg_kept", dut_rf[0], 32'h0);
        chk("reg5_written", dut_rf[5], 32'hDEADBEEF);

        // Reset during sweep index 10, then a request stalls through the whole restart sweep.
        reset_n = 1'b0;
        run_steps(2);
        reset_n = 1'b1;
        run_steps(10);
        reset_n = 1'b0;
        step();
        chk("midsweep_rw", RegWrite, 1'b0);
        chk("midsweep_done", init_done, 1'b0);
        reset_n = 1'b1;
        set_req(0, 1'b1, 5'd9, 32'h99);
        run_steps(NUM_REGS);
        step();
        chk("stall_grant", ready_seen, 2'b01);
        set_req(0, 1'b0, 5'd9, 32'h99);
        step();

        // Reset while a RUN request would be accepted; the request is re-granted after the sweep.
        set_req(1, 1'b1, 5'd12, 32'hC0FFEE);
        reset_n = 1'b0;
        step();
        chk("midrun_ready", ready_seen, 2'b00);
        reset_n = 1'b1;
        run_steps(NUM_REGS);
        step();
        chk("regrant", ready_seen, 2'b10);
        set_req(1, 1'b0, 5'd12, 32'hC0FFEE);
        run_steps(2);
        chk("reg12_written", dut_rf[12], 32'hC0FFEE);

        // Randomized traffic with requesters holding their request until accepted.
        for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) != 0) begin
                    pend_v[i] = 1'b1;
                    pend_r[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom_range(0, 31));
                    pend_d[i] = $urandom;
                end
                set_req(i, pend_v[i], pend_r[i], pend_d[i]);
            end
            step();
            if (last_grant >= 0) pend_v[last_grant] = 1'b0;
        end
        reset_n   = 1'b1;
        req_valid = '0;
        run_steps(NUM_REGS + 3);
        for (int i = 0; i < NUM_REGS; i++) chk("rf_contents", dut_rf[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
